// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, pointer state type and opcode classification helpers.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Round-robin pointer: which port won the most recent transfer.
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_id_e;

  function automatic logic is_legal_op(input logic [3:0] ctl);
    logic legal;
    case (ctl)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic is_arith_op(input logic [3:0] ctl);
    return (ctl == OP_ADD) || (ctl == OP_SUB);
  endfunction

endpackage

// File: rtl/alu.sv
// Team combinational ALU: AND/OR/ADD/SUB/SLT(unsigned)/NOR.
// Overflow always reports the adder (or subtractor for SUB) and is only meaningful for ADD/SUB.
module alu
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   ALUctl,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] ALUOut,
  output logic         Zero,
  output logic         Overflow
);

  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;

  assign w_sum  = A + B;
  assign w_diff = A - B;

  // Result select by opcode; illegal opcodes produce zero.
  always_comb begin
    ALUOut = '0;
    case (ALUctl)
      OP_AND:  ALUOut = A & B;
      OP_OR:   ALUOut = A | B;
      OP_ADD:  ALUOut = w_sum;
      OP_SUB:  ALUOut = w_diff;
      OP_SLT:  ALUOut = {{(W-1){1'b0}}, (A < B)};
      OP_NOR:  ALUOut = ~(A | B);
      default: ALUOut = '0;
    endcase
  end

  // Signed overflow of the adder path, valid only when the op is ADD or SUB.
  always_comb begin
    if (ALUctl == OP_SUB)
      Overflow = (A[W-1] != B[W-1]) && (w_diff[W-1] != A[W-1]);
    else
      Overflow = (A[W-1] == B[W-1]) && (w_sum[W-1] != A[W-1]);
  end

  assign Zero = (ALUOut == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from valid and the last-winner pointer.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  last_id_e r_last;
  last_id_e w_last_next;

  // Pointer register; port 0 wins the first contention after reset.
  always_ff @(posedge clock) begin
    if (reset) r_last <= LAST1;
    else       r_last <= w_last_next;
  end

  // Pointer moves to the winner only when a transfer happens.
  always_comb begin
    w_last_next = r_last;
    if (advance) w_last_next = grant[1] ? LAST1 : LAST0;
  end

  // Grant: lone requester wins; on contention the port that did not win last time wins.
  always_comb begin
    grant = '0;
    if (!reset) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (r_last == LAST0) ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, 2-stage pipeline, tagged response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_ctl,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_ctl,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_overflow,
  output logic         rsp_zero,
  output logic         rsp_err
);

  logic [1:0]   w_valid;
  logic [1:0]   w_grant;
  logic         w_xfer;

  logic         r_s1_valid;
  logic         r_s1_id;
  logic [3:0]   r_s1_ctl;
  logic [W-1:0] r_s1_a;
  logic [W-1:0] r_s1_b;

  logic [W-1:0] w_alu_out;
  logic         w_alu_zero;
  logic         w_alu_ovf;
  logic         w_legal;
  logic [W-1:0] w_result;
  logic         w_ovf;
  logic         w_zero;
  logic         w_err;

  logic         r_rsp_valid;
  logic         r_rsp_id;
  logic [W-1:0] r_rsp_data;
  logic         r_rsp_ovf;
  logic         r_rsp_zero;
  logic         r_rsp_err;

  assign w_valid    = {req1_valid, req0_valid};
  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_xfer     = |(w_valid & w_grant);

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .valid   (w_valid),
    .advance (w_xfer),
    .grant   (w_grant)
  );

  // Stage 1: capture the granted request; idle cycles leave the stage zeroed.
  always_ff @(posedge clock) begin
    if (reset || !w_xfer) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= 1'b0;
      r_s1_ctl   <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      r_s1_valid <= 1'b1;
      r_s1_id    <= w_grant[1];
      r_s1_ctl   <= w_grant[1] ? req1_ctl : req0_ctl;
      r_s1_a     <= w_grant[1] ? req1_a   : req0_a;
      r_s1_b     <= w_grant[1] ? req1_b   : req0_b;
    end
  end

  alu #(.W(W)) u_alu (
    .ALUctl   (r_s1_ctl),
    .A        (r_s1_a),
    .B        (r_s1_b),
    .ALUOut   (w_alu_out),
    .Zero     (w_alu_zero),
    .Overflow (w_alu_ovf)
  );

  // Sanitise ALU outputs: zero result on illegal ops, overflow only for ADD/SUB.
  always_comb begin
    w_legal  = is_legal_op(r_s1_ctl);
    w_result = (r_s1_valid && w_legal) ? w_alu_out : '0;
    w_ovf    = r_s1_valid && is_arith_op(r_s1_ctl) && w_alu_ovf;
    w_zero   = r_s1_valid && (w_legal ? w_alu_zero : 1'b1);
    w_err    = r_s1_valid && !w_legal;
  end

  // Stage 2: response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= r_s1_valid;
      r_rsp_id    <= r_s1_id;
      r_rsp_data  <= w_result;
      r_rsp_ovf   <= w_ovf;
      r_rsp_zero  <= w_zero;
      r_rsp_err   <= w_err;
    end
  end

  // Outputs are masked during reset so a response already registered before
  // reset asserted is never presented while the pipeline is being discarded.
  assign rsp_valid    = r_rsp_valid & ~reset;
  assign rsp_id       = r_rsp_id    & ~reset;
  assign rsp_data     = reset ? '0 : r_rsp_data;
  assign rsp_overflow = r_rsp_ovf   & ~reset;
  assign rsp_zero     = r_rsp_zero  & ~reset;
  assign rsp_err      = r_rsp_err   & ~reset;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready;
  logic [3:0]   req0_ctl;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [3:0]   req1_ctl;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_id, rsp_overflow, rsp_zero, rsp_err;
  logic [W-1:0] rsp_data;

  alu_arbiter #(.W(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_ctl     (req0_ctl),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_ctl     (req1_ctl),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        v;
    logic        id;
    logic [31:0] data;
    logic        ovf;
    logic        zero;
    logic        err;
  } rsp_t;

  int   checks   = 0;
  int   failures = 0;
  rsp_t pipe0, pipe1;   // pipe0: accepted last cycle, pipe1: accepted two cycles ago
  logic m_last;         // port that won the most recent transfer
  logic o_rdy0, o_rdy1;
  rsp_t o_rsp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result from the opcode definitions, using wide signed arithmetic for overflow.
  function automatic rsp_t ref_rsp(input logic id, input logic [3:0] ctl,
                                   input logic [31:0] a, input logic [31:0] b);
    rsp_t   r;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    r = '0;
    r.v  = 1'b1;
    r.id = id;
    case (ctl)
      4'b0000: r.data = a & b;
      4'b0001: r.data = a | b;
      4'b0010: begin
        s = sa + sb;
        r.data = s[31:0];
        r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sa - sb;
        r.data = s[31:0];
        r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r.data = (a < b) ? 32'd1 : 32'd0;
      4'b1100: r.data = ~(a | b);
      default: begin r.data = '0; r.err = 1'b1; end
    endcase
    r.zero = (r.data == 32'd0);
    return r;
  endfunction

  // One clock cycle: drive inputs, check ready and response at the falling edge, advance model.
  task automatic cycle(input logic rst,
                       input logic v0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1);
    logic eg0, eg1;
    rsp_t exp, n;
    reset = rst;
    req0_valid = v0; req0_ctl = c0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_ctl = c1; req1_a = a1; req1_b = b1;
    @(negedge clock);
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rst) begin
      if (v0 && v1) begin
        if (m_last) eg0 = 1'b1;
        else        eg1 = 1'b1;
      end else begin
        eg0 = v0;
        eg1 = v1;
      end
    end
    o_rdy0 = req0_ready;
    o_rdy1 = req1_ready;
    o_rsp  = '{v: rsp_valid, id: rsp_id, data: rsp_data, ovf: rsp_overflow,
               zero: rsp_zero, err: rsp_err};
    exp = rst ? rsp_t'('0) : pipe1;
    chk("req0_ready", 64'(o_rdy0), 64'(eg0));
    chk("req1_ready", 64'(o_rdy1), 64'(eg1));
    chk("rsp_valid", 64'(o_rsp.v), 64'(exp.v));
    chk("rsp_id", 64'(o_rsp.id), 64'(exp.id));
    chk("rsp_data", 64'(o_rsp.data), 64'(exp.data));
    chk("rsp_overflow", 64'(o_rsp.ovf), 64'(exp.ovf));
    chk("rsp_zero", 64'(o_rsp.zero), 64'(exp.zero));
    chk("rsp_err", 64'(o_rsp.err), 64'(exp.err));
    n = '0;
    if (eg0)      n = ref_rsp(1'b0, c0, a0, b0);
    else if (eg1) n = ref_rsp(1'b1, c1, a1, b1);
    if (rst) begin
      pipe0  = '0;
      pipe1  = '0;
      m_last = 1'b1;
    end else begin
      pipe1 = pipe0;
      pipe0 = n;
      if (eg0)      m_last = 1'b0;
      else if (eg1) m_last = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0000_0000;
      1:       v = 32'h0000_0001;
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] pick_op();
    logic [3:0] op;
    case ($urandom_range(0, 6))
      0:       op = 4'b0000;
      1:       op = 4'b0001;
      2:       op = 4'b0010;
      3:       op = 4'b0110;
      4:       op = 4'b0111;
      5:       op = 4'b1100;
      default: op = 4'($urandom_range(0, 15));
    endcase
    return op;
  endfunction

  initial begin
    pipe0 = '0; pipe1 = '0; m_last = 1'b1;
    reset = 1'b1;
    req0_valid = 1'b0; req0_ctl = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_ctl = '0; req1_a = '0; req1_b = '0;
    @(posedge clock);
    #1;

    // Requests during reset must not be accepted.
    cycle(1'b1, 1'b1, 4'b0010, 32'd1, 32'd2, 1'b1, 4'b0010, 32'd3, 32'd4);
    cycle(1'b1, 1'b1, 4'b0010, 32'd1, 32'd2, 1'b1, 4'b0010, 32'd3, 32'd4);

    // Single request: port 0 ADD 5+7.
    cycle(1'b0, 1'b1, 4'b0010, 32'd5, 32'd7, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("single_ready0", 64'(o_rdy0), 64'd1);
    idle();
    idle();
    chk("single_valid", 64'(o_rsp.v), 64'd1);
    chk("single_id", 64'(o_rsp.id), 64'd0);
    chk("single_data", 64'(o_rsp.data), 64'd12);
    chk("single_flags", 64'({o_rsp.ovf, o_rsp.zero, o_rsp.err}), 64'd0);

    // Contention fairness from a fresh pointer.
    cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) cycle(1'b0, 1'b1, 4'b0110, 32'd10, 32'd3, 1'b1, 4'b0001, 32'hF0, 32'h0F);
      else       idle();
      if (i < 4) chk("fair_grant0", 64'(o_rdy0), 64'((i % 2) == 0));
      if (i >= 2) begin
        chk("fair_id", 64'(o_rsp.id), 64'(i % 2));
        chk("fair_data", 64'(o_rsp.data), ((i % 2) == 0) ? 64'd7 : 64'hFF);
      end
    end

    // Signed overflow, then masking on a following logical op.
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1);
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd0);
    idle();
    chk("ovf_data", 64'(o_rsp.data), 64'h8000_0000);
    chk("ovf_flag", 64'(o_rsp.ovf), 64'd1);
    idle();
    chk("and_data", 64'(o_rsp.data), 64'd0);
    chk("and_zero", 64'(o_rsp.zero), 64'd1);
    chk("and_ovf", 64'(o_rsp.ovf), 64'd0);

    // Illegal opcode.
    cycle(1'b0, 1'b1, 4'b0101, 32'd3, 32'd4, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("illegal_accept", 64'(o_rdy0), 64'd1);
    idle();
    idle();
    chk("illegal_flags", 64'({o_rsp.v, o_rsp.err, o_rsp.ovf, o_rsp.zero}), 64'b1101);
    chk("illegal_data", 64'(o_rsp.data), 64'd0);

    // SLT / NOR back-to-back on port 0.
    cycle(1'b0, 1'b1, 4'b0111, 32'd2, 32'd9, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 4'b0111, 32'd9, 32'd2, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 4'b1100, 32'd0, 32'd0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("b2b_data0", 64'({o_rsp.v, o_rsp.data}), {31'd0, 1'b1, 32'd1});
    idle();
    chk("b2b_data1", 64'({o_rsp.v, o_rsp.data}), {31'd0, 1'b1, 32'd0});
    idle();
    chk("b2b_data2", 64'({o_rsp.v, o_rsp.data}), {31'd0, 1'b1, 32'hFFFF_FFFF});

    // Reset mid-flight discards both accepted requests.
    cycle(1'b0, 1'b1, 4'b0010, 32'd1, 32'd1, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 4'b0010, 32'd2, 32'd2, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst_mid_valid_r", 64'(o_rsp.v), 64'd0);
    idle();
    chk("rst_mid_valid_a", 64'(o_rsp.v), 64'd0);
    idle();
    chk("rst_mid_valid_b", 64'(o_rsp.v), 64'd0);
    cycle(1'b0, 1'b1, 4'b0000, 32'd1, 32'd1, 1'b1, 4'b0001, 32'd2, 32'd2);
    chk("rst_mid_grant", 64'({o_rdy1, o_rdy0}), 64'b01);
    idle();
    idle();

    // Random traffic with occasional resets; operands change freely while waiting.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0), pick_op(), pick_operand(), pick_operand(),
            ($urandom_range(0, 3) != 0), pick_op(), pick_operand(), pick_operand());
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
